// File: rtl/ch_queue_ext.sv
// Parametrised ready/valid FIFO: power-of-two depth, synchronous flush, occupancy flags,
// and an optional mode where a full queue accepts an enqueue whenever the consumer dequeues.
module ch_queue_ext #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter int unsigned PIPE          = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_flush,
  input  logic                         io_enq_valid,
  input  logic [DATA_WIDTH-1:0]        io_enq_data,
  output logic                         io_enq_ready,
  input  logic                         io_deq_ready,
  output logic                         io_deq_valid,
  output logic [DATA_WIDTH-1:0]        io_deq_data,
  output logic [$clog2(DEPTH):0]       io_size,
  output logic                         io_almost_full,
  output logic                         io_almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);
  localparam logic          PIPE_EN  = (PIPE != 0);

  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_enq_fire;
  logic w_deq_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign io_deq_valid = !w_empty && !io_flush;
  assign io_enq_ready = (!w_full || (PIPE_EN && io_deq_ready)) && !io_flush;

  assign w_enq_fire = io_enq_valid && io_enq_ready;
  assign w_deq_fire = io_deq_valid && io_deq_ready;

  // First-word-fall-through head; a pipelined full-queue write lands after this read
  assign io_deq_data = r_mem[r_rd_ptr[AW-1:0]];

  assign io_size         = r_wr_ptr - r_rd_ptr;
  assign io_almost_full  = (io_size >= AFULL_T);
  assign io_almost_empty = (io_size <= AEMPTY_T);

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_wr_ptr[AW-1:0]] <= io_enq_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (io_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: doc/ch_queue_ext.md
Name: ch_queue_ext

Overview:
- Parametrised successor of the two-entry queue: ready/valid FIFO, configurable data width and power-of-two depth.
- Adds synchronous flush, almost-full/almost-empty flags, and optional pipelined enqueue when full (enq accepted in the same cycle as a deq).
- Sits between producer/consumer modules inside generated designs and is instantiated through the usual module binding.

Parameters:
- DATA_WIDTH, 4: payload bits per entry.
- DEPTH, 4: number of entries; power of two, >= 2.
- AFULL_THRESH, DEPTH-1: io_almost_full asserted when occupancy >= this value; range 1..DEPTH.
- AEMPTY_THRESH, 1: io_almost_empty asserted when occupancy <= this value; range 0..DEPTH-1.
- PIPE, 0: if 1, a full queue accepts an enq in any cycle where io_deq_ready=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_flush  in  1  synchronous clear of all entries.
- io_enq_valid  in  1  producer has data.
- io_enq_data  in  DATA_WIDTH  enqueue payload.
- io_enq_ready  out  1  queue can accept.
- io_deq_ready  in  1  consumer accepts.
- io_deq_valid  out  1  head entry valid.
- io_deq_data  out  DATA_WIDTH  head entry payload.
- io_size  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- io_almost_full  out  1  occupancy threshold flag.
- io_almost_empty  out  1  occupancy threshold flag.

Behaviour:
- State: rd_ptr and wr_ptr, each log2(DEPTH)+1 bits; the extra MSB is the wrap bit. Storage array is DEPTH x DATA_WIDTH and is not reset.
- Pointer arithmetic is modulo 2^(log2(DEPTH)+1). Index = low log2(DEPTH) bits. io_size = wr_ptr - rd_ptr at the same width.
- empty = (wr_ptr == rd_ptr).
- full = low bits equal AND wrap bits differ.
- io_deq_valid = !empty & !io_flush.
- io_enq_ready = (!full | (PIPE & io_deq_ready)) & !io_flush.
- enq_fire = io_enq_valid & io_enq_ready. On fire: mem[wr_ptr index] <= io_enq_data and wr_ptr += 1.
- deq_fire = io_deq_valid & io_deq_ready. On fire: rd_ptr += 1.
- Simultaneous enq_fire and deq_fire: both pointers advance and occupancy is unchanged.
- Full with PIPE=1 and io_deq_ready=1: the enq writes the slot being vacated. Read is combinational from the old head, so io_deq_data is correct in that cycle.
- Read is first-word-fall-through: io_deq_data = mem[rd_ptr index] combinationally, zero-cycle latency from registered state. Data written at edge N is visible at io_deq_data after edge N.
- Enq-to-deq latency is 1 cycle when the queue is empty; there is no bypass.
- io_deq_data is don't-care while io_deq_valid=0.
- Flags are combinational from io_size:
  - io_almost_full = (io_size >= AFULL_THRESH).
  - io_almost_empty = (io_size <= AEMPTY_THRESH).
- Flush: while io_flush=1, io_enq_ready=0 and io_deq_valid=0, so no fire occurs. At the next edge both pointers <= 0. Flush takes priority over everything.
- Reset (async, any time, including mid-transfer): pointers <= 0 immediately. Outputs then read io_deq_valid=0, io_enq_ready=1 (if io_flush=0), io_size=0, io_almost_empty=1, io_almost_full=0.
- Handshake rules:
  - io_enq_ready does not depend on io_enq_valid.
  - io_deq_valid does not depend on io_deq_ready.
  - io_enq_ready depends on io_deq_ready only when PIPE=1.
- Producer may drop io_enq_valid without a fire; the queue takes no action.
- Occupancy never exceeds DEPTH and never goes below 0 by construction. Wrap-around at pointer index DEPTH-1 -> 0 is seamless.

Test Plan:
- DATA_WIDTH=8, DEPTH=4: enq 0x11,0x22,0x33,0x44 on consecutive cycles with deq_ready=0 -> io_size 1,2,3,4; io_enq_ready=0 after the 4th; io_almost_full=1 from size 3; io_deq_data=0x11.
- From full, deq_ready=1 for 4 cycles -> io_deq_data sequence 0x11,0x22,0x33,0x44; io_deq_valid=0 and io_almost_empty=1 at end; io_size=0.
- Wrap: 10 cycles with enq and deq both firing every cycle, data 0..9 -> each output value equals the input of the previous cycle; io_size stays 1; pointers wrap twice.
- PIPE=1, full queue holding 0xA0..0xA3: enq 0xB0 with deq_ready=1 -> enq fires; io_deq_data=0xA0 that cycle; io_size stays 4; 0xB0 emerges 4 deqs later. PIPE=0, same stimulus -> enq not accepted.
- Flush with 3 entries and io_enq_valid=1 -> io_enq_ready=0 and io_deq_valid=0 during flush; next cycle io_size=0; the 0x55 offered during flush is absent.
- Assert reset asynchronously mid-cycle with 2 entries -> io_deq_valid and io_size go to 0 before the next clock edge; after release, the first enq of 0x7E appears at io_deq_data one cycle later.
